// File: rtl/next_piece_queue_if.sv
// Handshake and display bundle between the next-piece queue and its consumer.
// The master side offers candidate IDs and spawn requests; the slave side is
// the queue, returning readiness, decoded shapes, preview IDs and status.
interface next_piece_queue_if #(
  parameter int DEPTH = 3,
  parameter int ROW_W = 10
);
  logic [2:0]           piece_in;
  logic                 piece_valid;
  logic                 piece_ready;
  logic                 take;
  logic                 cur_valid;
  logic [2*ROW_W-1:0]   new_block;
  logic [2*ROW_W-1:0]   next_block;
  logic [DEPTH*3-1:0]   preview_ids;
  logic [2:0]           count;
  logic                 take_err;

  modport master (
    output piece_in, piece_valid, take,
    input  piece_ready, cur_valid, new_block, next_block, preview_ids, count, take_err
  );

  modport slave (
    input  piece_in, piece_valid, take,
    output piece_ready, cur_valid, new_block, next_block, preview_ids, count, take_err
  );
endinterface

// File: rtl/next_piece_queue.sv
// Next-piece queue: a compacted FIFO of DEPTH+1 piece slots (slot 0 = current
// piece) with optional 7-bag de-duplication and shape decode for display.
// Block rows are packed as {row1, row0}, row0 in the low ROW_W bits.
module next_piece_queue #(
  parameter int DEPTH     = 3,
  parameter int ROW_W     = 10,
  parameter int SPAWN_COL = 6,
  parameter int BAG_MODE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  next_piece_queue_if.slave   bus
);

  localparam int SLOTS = DEPTH + 1;

  logic [2:0]       id_q  [SLOTS];
  logic [2:0]       id_d  [SLOTS];
  logic [SLOTS-1:0] vld_q, vld_d;
  logic [2:0]       count_q, count_d;
  logic [6:0]       used_q, used_d;
  logic             take_err_q, take_err_d;

  logic             pop;
  logic             acc;
  logic             room;
  logic             bag_ok;
  logic [2:0]       wr_idx;
  logic [7:0]       used_ext;
  logic [6:0]       used_set;

  // Shape lookup: 4-bit row patterns placed so the pattern MSB lands on SPAWN_COL.
  function automatic logic [2*ROW_W-1:0] decode(input logic valid, input logic [2:0] id);
    logic [3:0]       r0;
    logic [3:0]       r1;
    logic [ROW_W-1:0] w0;
    logic [ROW_W-1:0] w1;
    case (id)
      3'd0:    begin r0 = 4'b0100; r1 = 4'b1110; end
      3'd1:    begin r0 = 4'b0010; r1 = 4'b1110; end
      3'd2:    begin r0 = 4'b1000; r1 = 4'b1110; end
      3'd3:    begin r0 = 4'b0110; r1 = 4'b1100; end
      3'd4:    begin r0 = 4'b1100; r1 = 4'b0110; end
      3'd5:    begin r0 = 4'b0110; r1 = 4'b0110; end
      3'd6:    begin r0 = 4'b0000; r1 = 4'b1111; end
      default: begin r0 = 4'b0000; r1 = 4'b0000; end
    endcase
    if (!valid) begin
      r0 = 4'b0000;
      r1 = 4'b0000;
    end
    w0 = ROW_W'(r0) << (SPAWN_COL - 3);
    w1 = ROW_W'(r1) << (SPAWN_COL - 3);
    return {w1, w0};
  endfunction

  // Accept/pop control; readiness already accounts for a same-cycle pop freeing room.
  always_comb begin
    used_ext        = {1'b0, used_q};
    pop             = bus.take && (count_q != 3'd0);
    room            = (count_q < 3'(SLOTS)) || pop;
    bag_ok          = (BAG_MODE == 0) || !used_ext[bus.piece_in];
    bus.piece_ready = (bus.piece_in != 3'd7) && room && bag_ok;
    acc             = bus.piece_valid && bus.piece_ready;
    wr_idx          = pop ? (count_q - 3'd1) : count_q;
    count_d         = count_q + {2'b00, acc} - {2'b00, pop};
    take_err_d      = bus.take && (count_q == 3'd0);
  end

  // Slot next-state: shift down on pop, then drop the new ID into the lowest free slot.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      id_d[k]  = id_q[k];
      vld_d[k] = vld_q[k];
    end
    if (pop) begin
      for (int k = 0; k < DEPTH; k++) begin
        id_d[k]  = id_q[k+1];
        vld_d[k] = vld_q[k+1];
      end
      id_d[DEPTH]  = 3'd0;
      vld_d[DEPTH] = 1'b0;
    end
    if (acc) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (wr_idx == 3'(k)) begin
          id_d[k]  = bus.piece_in;
          vld_d[k] = 1'b1;
        end
      end
    end
  end

  // Bag mask: mark each accepted ID, restarting the bag when all seven are used.
  always_comb begin
    used_set = used_q | (7'd1 << bus.piece_in);
    used_d   = used_q;
    if (BAG_MODE == 0) begin
      used_d = 7'h00;
    end else if (acc) begin
      used_d = (used_set == 7'h7F) ? 7'h00 : used_set;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        id_q[k] <= 3'd0;
      end
      vld_q      <= '0;
      count_q    <= 3'd0;
      used_q     <= 7'h00;
      take_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        id_q[k] <= id_d[k];
      end
      vld_q      <= vld_d;
      count_q    <= count_d;
      used_q     <= used_d;
      take_err_q <= take_err_d;
    end
  end

  assign bus.cur_valid  = vld_q[0];
  assign bus.count      = count_q;
  assign bus.take_err   = take_err_q;
  assign bus.new_block  = decode(vld_q[0], id_q[0]);
  assign bus.next_block = decode(vld_q[1], id_q[1]);

  // Preview fields read zero for empty slots.
  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_preview
    assign bus.preview_ids[3*gi-1 -: 3] = vld_q[gi] ? id_q[gi] : 3'b000;
  end

endmodule

// File: tb/tb_next_piece_queue.sv
// Directed bench for next_piece_queue: one bag-mode and one plain instance
// sharing clock and reset, each scenario a task with inline comparisons.
module tb_next_piece_queue;

  localparam int DEPTH = 3;
  localparam int ROW_W = 10;

  localparam logic [2*ROW_W-1:0] T_BLK = {10'h070, 10'h020};
  localparam logic [2*ROW_W-1:0] J_BLK = {10'h070, 10'h010};
  localparam logic [2*ROW_W-1:0] L_BLK = {10'h070, 10'h040};
  localparam logic [2*ROW_W-1:0] Z_BLK = {10'h030, 10'h060};

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  next_piece_queue_if #(.DEPTH(DEPTH), .ROW_W(ROW_W)) ifb ();
  next_piece_queue_if #(.DEPTH(DEPTH), .ROW_W(ROW_W)) ifn ();

  next_piece_queue #(.DEPTH(DEPTH), .ROW_W(ROW_W), .SPAWN_COL(6), .BAG_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );
  next_piece_queue #(.DEPTH(DEPTH), .ROW_W(ROW_W), .SPAWN_COL(6), .BAG_MODE(0)) dut_n (
    .clk(clk), .reset(reset), .bus(ifn.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifb.piece_in = 3'd0; ifb.piece_valid = 1'b0; ifb.take = 1'b0;
    ifn.piece_in = 3'd0; ifn.piece_valid = 1'b0; ifn.take = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle();
    cyc();
    reset = 1'b1;
  endtask

  task automatic offer_b(input logic [2:0] id, input logic tk);
    ifb.piece_in = id; ifb.piece_valid = 1'b1; ifb.take = tk;
    $display("txn bag offer=%0d take=%0d ready=%0d count=%0d", id, tk, ifb.piece_ready, ifb.count);
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    cyc();
    checks++; if (ifb.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ifb.count); end
    checks++; if (ifb.cur_valid !== 1'b0) begin failures++; $display("FAIL rst_cur_valid got=%0b exp=0", ifb.cur_valid); end
    checks++; if (ifb.new_block !== '0) begin failures++; $display("FAIL rst_new_block got=%h exp=0", ifb.new_block); end
    checks++; if (ifb.next_block !== '0) begin failures++; $display("FAIL rst_next_block got=%h exp=0", ifb.next_block); end
    checks++; if (ifb.preview_ids !== 9'd0) begin failures++; $display("FAIL rst_preview got=%h exp=0", ifb.preview_ids); end
    checks++; if (ifb.take_err !== 1'b0) begin failures++; $display("FAIL rst_take_err got=%0b exp=0", ifb.take_err); end
    reset = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_empty got=%0b exp=1", ifb.piece_ready); end
    $display("txn reset done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) offer_b(3'(i), 1'b0);
    checks++; if (ifb.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", ifb.count); end
    checks++; if (ifb.cur_valid !== 1'b1) begin failures++; $display("FAIL fill_cur_valid got=%0b exp=1", ifb.cur_valid); end
    checks++; if (ifb.new_block !== T_BLK) begin failures++; $display("FAIL fill_new_block got=%h exp=%h", ifb.new_block, T_BLK); end
    checks++; if (ifb.next_block !== J_BLK) begin failures++; $display("FAIL fill_next_block got=%h exp=%h", ifb.next_block, J_BLK); end
    checks++; if (ifb.preview_ids !== 9'b011_010_001) begin failures++; $display("FAIL fill_preview got=%b exp=011010001", ifb.preview_ids); end
    checks++; if (dut_b.used_q !== 7'h0F) begin failures++; $display("FAIL fill_used got=%h exp=0f", dut_b.used_q); end
    ifb.piece_in = 3'd4; ifb.piece_valid = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", ifb.piece_ready); end
    cyc();
    idle();
    checks++; if (ifb.preview_ids !== 9'b011_010_001) begin failures++; $display("FAIL full_no_store got=%b exp=011010001", ifb.preview_ids); end
    $display("txn bag full offer=4 rejected");
  endtask

  task automatic test_back_to_back();
    ifb.take = 1'b1; ifb.piece_in = 3'd6; ifb.piece_valid = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", ifb.piece_ready); end
    cyc();
    idle();
    $display("txn bag take+offer=6 count=%0d", ifb.count);
    checks++; if (ifb.count !== 3'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", ifb.count); end
    checks++; if (ifb.new_block !== J_BLK) begin failures++; $display("FAIL b2b_slot0 got=%h exp=%h", ifb.new_block, J_BLK); end
    checks++; if (ifb.preview_ids !== 9'b110_011_010) begin failures++; $display("FAIL b2b_preview got=%b exp=110011010", ifb.preview_ids); end
  endtask

  task automatic test_bag();
    apply_reset();
    for (int i = 0; i < 4; i++) offer_b(3'(i), 1'b0);
    offer_b(3'd4, 1'b1);
    offer_b(3'd5, 1'b1);
    ifb.take = 1'b1; cyc(); cyc(); idle();
    checks++; if (ifb.count !== 3'd2) begin failures++; $display("FAIL bag_drain_count got=%0d exp=2", ifb.count); end
    ifb.piece_in = 3'd3; ifb.piece_valid = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b0) begin failures++; $display("FAIL bag_dup_ready got=%0b exp=0", ifb.piece_ready); end
    cyc();
    idle();
    checks++; if (ifb.count !== 3'd2) begin failures++; $display("FAIL bag_dup_count got=%0d exp=2", ifb.count); end
    checks++; if (ifb.preview_ids !== 9'b000_000_101) begin failures++; $display("FAIL bag_dup_preview got=%b exp=000000101", ifb.preview_ids); end
    ifb.piece_in = 3'd6; ifb.piece_valid = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b1) begin failures++; $display("FAIL bag_last_ready got=%0b exp=1", ifb.piece_ready); end
    offer_b(3'd6, 1'b0);
    checks++; if (dut_b.used_q !== 7'h00) begin failures++; $display("FAIL bag_clear got=%h exp=00", dut_b.used_q); end
    ifb.piece_in = 3'd3; ifb.piece_valid = 1'b1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b1) begin failures++; $display("FAIL bag_reuse_ready got=%0b exp=1", ifb.piece_ready); end
    offer_b(3'd3, 1'b0);
    checks++; if (ifb.count !== 3'd4) begin failures++; $display("FAIL bag_reuse_count got=%0d exp=4", ifb.count); end
    checks++; if (ifb.preview_ids !== 9'b011_110_101) begin failures++; $display("FAIL bag_reuse_preview got=%b exp=011110101", ifb.preview_ids); end
    checks++; if (ifb.new_block !== Z_BLK) begin failures++; $display("FAIL bag_reuse_slot0 got=%h exp=%h", ifb.new_block, Z_BLK); end
  endtask

  task automatic test_take_empty();
    apply_reset();
    ifb.take = 1'b1;
    cyc();
    idle();
    $display("txn bag take on empty take_err=%0b", ifb.take_err);
    checks++; if (ifb.take_err !== 1'b1) begin failures++; $display("FAIL empty_take_err got=%0b exp=1", ifb.take_err); end
    checks++; if (ifb.count !== 3'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", ifb.count); end
    checks++; if (ifb.new_block !== '0) begin failures++; $display("FAIL empty_new_block got=%h exp=0", ifb.new_block); end
    cyc();
    checks++; if (ifb.take_err !== 1'b0) begin failures++; $display("FAIL empty_err_pulse got=%0b exp=0", ifb.take_err); end
    offer_b(3'd2, 1'b1);
    checks++; if (ifb.take_err !== 1'b1) begin failures++; $display("FAIL empty_acc_err got=%0b exp=1", ifb.take_err); end
    checks++; if (ifb.count !== 3'd1) begin failures++; $display("FAIL empty_acc_count got=%0d exp=1", ifb.count); end
    checks++; if (ifb.new_block !== L_BLK) begin failures++; $display("FAIL empty_acc_slot0 got=%h exp=%h", ifb.new_block, L_BLK); end
  endtask

  task automatic test_id7();
    apply_reset();
    ifb.piece_in = 3'd1; ifb.piece_valid = 1'b1;
    ifn.piece_in = 3'd1; ifn.piece_valid = 1'b1;
    cyc();
    ifb.piece_in = 3'd7; ifn.piece_in = 3'd7;
    #1;
    checks++; if (ifb.piece_ready !== 1'b0) begin failures++; $display("FAIL id7_ready_bag got=%0b exp=0", ifb.piece_ready); end
    checks++; if (ifn.piece_ready !== 1'b0) begin failures++; $display("FAIL id7_ready_plain got=%0b exp=0", ifn.piece_ready); end
    cyc();
    $display("txn both offer=7 counts=%0d/%0d", ifb.count, ifn.count);
    checks++; if (ifb.count !== 3'd1) begin failures++; $display("FAIL id7_count_bag got=%0d exp=1", ifb.count); end
    checks++; if (ifn.count !== 3'd1) begin failures++; $display("FAIL id7_count_plain got=%0d exp=1", ifn.count); end
    checks++; if (dut_b.used_q !== 7'h02) begin failures++; $display("FAIL id7_used_bag got=%h exp=02", dut_b.used_q); end
    checks++; if (ifn.new_block !== J_BLK) begin failures++; $display("FAIL id7_slot0_plain got=%h exp=%h", ifn.new_block, J_BLK); end
    ifb.piece_in = 3'd1; ifn.piece_in = 3'd1;
    #1;
    checks++; if (ifb.piece_ready !== 1'b0) begin failures++; $display("FAIL dup_ready_bag got=%0b exp=0", ifb.piece_ready); end
    checks++; if (ifn.piece_ready !== 1'b1) begin failures++; $display("FAIL dup_ready_plain got=%0b exp=1", ifn.piece_ready); end
    cyc();
    idle();
    checks++; if (ifn.count !== 3'd2) begin failures++; $display("FAIL dup_count_plain got=%0d exp=2", ifn.count); end
    checks++; if (dut_n.used_q !== 7'h00) begin failures++; $display("FAIL plain_used got=%h exp=00", dut_n.used_q); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    offer_b(3'd4, 1'b0);
    offer_b(3'd5, 1'b0);
    ifb.take = 1'b1; ifb.piece_in = 3'd6; ifb.piece_valid = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    $display("txn async reset mid-cycle count=%0d", ifb.count);
    checks++; if (ifb.count !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", ifb.count); end
    checks++; if (ifb.cur_valid !== 1'b0) begin failures++; $display("FAIL ar_cur_valid got=%0b exp=0", ifb.cur_valid); end
    checks++; if (ifb.new_block !== '0) begin failures++; $display("FAIL ar_new_block got=%h exp=0", ifb.new_block); end
    checks++; if (ifb.next_block !== '0) begin failures++; $display("FAIL ar_next_block got=%h exp=0", ifb.next_block); end
    checks++; if (ifb.preview_ids !== 9'd0) begin failures++; $display("FAIL ar_preview got=%h exp=0", ifb.preview_ids); end
    checks++; if (ifb.take_err !== 1'b0) begin failures++; $display("FAIL ar_take_err got=%0b exp=0", ifb.take_err); end
    cyc();
    idle();
    reset = 1'b1;
    offer_b(3'd2, 1'b0);
    offer_b(3'd6, 1'b0);
    checks++; if (ifb.count !== 3'd2) begin failures++; $display("FAIL ar_refill_count got=%0d exp=2", ifb.count); end
    checks++; if (ifb.new_block !== L_BLK) begin failures++; $display("FAIL ar_refill_slot0 got=%h exp=%h", ifb.new_block, L_BLK); end
    checks++; if (ifb.preview_ids !== 9'b000_000_110) begin failures++; $display("FAIL ar_refill_preview got=%b exp=000000110", ifb.preview_ids); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_back_to_back();
    test_bag();
    test_take_empty();
    test_id7();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
